operand_collector_unit: RTL

- Per-warp operand collector that sits directly downstream of the register-file banks.
- Accepts one issued instruction carrying up to three source operands, each given as a (bank, row) pair.
- Issues one read request per operand to the bank arbiter, then captures returning bank data whose OCID tag equals this unit's ID.
- When every operand is present, presents the instruction plus operand data to the execution stage with a valid/ready handshake.

---
 rtl/operand_collector_unit_if.sv | 53 +++++
 rtl/operand_collector_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/operand_collector_unit_if.sv
// Bundle of issue, bank-arbiter, bank-response and dispatch signals for one operand collector.
interface operand_collector_unit_if #(
    parameter int unsigned DATA      = 256,
    parameter int unsigned ADDR      = 3,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned INSTR     = 32
) ();
    logic                      in_valid;
    logic                      in_ready;
    logic [2:0]                in_warp_id;
    logic [INSTR-1:0]          in_instr;
    logic [1:0]                in_src_count;
    logic [5:0]                in_src_bank;
    logic [3*ADDR-1:0]         in_src_addr;

    logic                      rd_req_valid;
    logic                      rd_req_ready;
    logic [1:0]                rd_req_bank;
    logic [ADDR-1:0]           rd_req_addr;
    logic [2:0]                rd_req_ocid;

    logic [NUM_BANKS-1:0]      rd_resp_valid;
    logic [3*NUM_BANKS-1:0]    rd_resp_ocid;
    logic [DATA*NUM_BANKS-1:0] rd_resp_data;

    logic                      out_valid;
    logic                      out_ready;
    logic [2:0]                out_warp_id;
    logic [INSTR-1:0]          out_instr;
    logic [DATA-1:0]           out_src0;
    logic [DATA-1:0]           out_src1;
    logic [DATA-1:0]           out_src2;

    modport slave (
        input  in_valid, in_warp_id, in_instr, in_src_count, in_src_bank, in_src_addr,
        output in_ready,
        output rd_req_valid, rd_req_bank, rd_req_addr, rd_req_ocid,
        input  rd_req_ready,
        input  rd_resp_valid, rd_resp_ocid, rd_resp_data,
        output out_valid, out_warp_id, out_instr, out_src0, out_src1, out_src2,
        input  out_ready
    );

    modport master (
        output in_valid, in_warp_id, in_instr, in_src_count, in_src_bank, in_src_addr,
        input  in_ready,
        input  rd_req_valid, rd_req_bank, rd_req_addr, rd_req_ocid,
        output rd_req_ready,
        output rd_resp_valid, rd_resp_ocid, rd_resp_data,
        input  out_valid, out_warp_id, out_instr, out_src0, out_src1, out_src2,
        output out_ready
    );
endinterface

// File: rtl/operand_collector_unit.sv
// Per-warp operand collector: requests up to three register-bank reads, captures tagged
// responses, then hands the instruction and its operands to the execution stage.
module operand_collector_unit #(
    parameter logic [2:0]  OC_ID     = 3'd0,
    parameter int unsigned DATA      = 256,
    parameter int unsigned ADDR      = 3,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned INSTR     = 32
) (
    input logic                   clk,
    input logic                   rst,
    operand_collector_unit_if.slave bus
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COLLECT  = 2'd1;
    localparam logic [1:0] ST_DISPATCH = 2'd2;

    localparam logic [1:0] SL_EMPTY = 2'd0;
    localparam logic [1:0] SL_REQ   = 2'd1;
    localparam logic [1:0] SL_WAIT  = 2'd2;
    localparam logic [1:0] SL_READY = 2'd3;

    logic [1:0]       state;
    logic [1:0]       slot_st   [3];
    logic [1:0]       slot_bank [3];
    logic [ADDR-1:0]  slot_addr [3];
    logic [DATA-1:0]  slot_data [3];
    logic [2:0]       warp_q;
    logic [INSTR-1:0] instr_q;

    logic [NUM_BANKS-1:0] resp_hit;
    logic [DATA-1:0]      resp_data [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_busy;
    logic [2:0]           sel;
    logic [2:0]           capture;
    logic                 any_sel;
    logic                 all_done;
    logic                 grant;
    logic [1:0]           req_bank;
    logic [ADDR-1:0]      req_addr;

    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            resp_hit[b]  = bus.rd_resp_valid[b] && (bus.rd_resp_ocid[3*b +: 3] == OC_ID);
            resp_data[b] = bus.rd_resp_data[DATA*b +: DATA];
        end
    end

    // Eligibility uses only registered WAIT state, so a same-cycle capture cannot unblock a bank.
    always_comb begin
        bank_busy = '0;
        sel       = '0;
        any_sel   = 1'b0;
        capture   = '0;
        all_done  = 1'b1;
        req_bank  = '0;
        req_addr  = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (slot_st[i] == SL_WAIT) bank_busy[slot_bank[i]] = 1'b1;
        end
        for (int unsigned i = 0; i < 3; i++) begin
            if (!any_sel && slot_st[i] == SL_REQ && !bank_busy[slot_bank[i]]) begin
                sel[i]   = 1'b1;
                any_sel  = 1'b1;
                req_bank = slot_bank[i];
                req_addr = slot_addr[i];
            end
            capture[i] = (state == ST_COLLECT) && (slot_st[i] == SL_WAIT) && resp_hit[slot_bank[i]];
            if (!(slot_st[i] == SL_READY || capture[i])) all_done = 1'b0;
        end
    end

    assign grant            = bus.rd_req_valid && bus.rd_req_ready;
    assign bus.in_ready     = (state == ST_IDLE);
    assign bus.rd_req_valid = (state == ST_COLLECT) && any_sel;
    assign bus.rd_req_bank  = req_bank;
    assign bus.rd_req_addr  = req_addr;
    assign bus.rd_req_ocid  = OC_ID;
    assign bus.out_valid    = (state == ST_DISPATCH);
    assign bus.out_warp_id  = warp_q;
    assign bus.out_instr    = instr_q;
    assign bus.out_src0     = slot_data[0];
    assign bus.out_src1     = slot_data[1];
    assign bus.out_src2     = slot_data[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            warp_q  <= '0;
            instr_q <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                slot_st[i]   <= SL_EMPTY;
                slot_bank[i] <= '0;
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        warp_q  <= bus.in_warp_id;
                        instr_q <= bus.in_instr;
                        for (int unsigned i = 0; i < 3; i++) begin
                            slot_bank[i] <= bus.in_src_bank[2*i +: 2];
                            slot_addr[i] <= bus.in_src_addr[ADDR*i +: ADDR];
                            slot_data[i] <= '0;
                            slot_st[i]   <= (i < 32'(bus.in_src_count)) ? SL_REQ : SL_READY;
                        end
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (capture[i]) begin
                            slot_data[i] <= resp_data[slot_bank[i]];
                            slot_st[i]   <= SL_READY;
                        end else if (grant && sel[i]) begin
                            slot_st[i] <= SL_WAIT;
                        end
                    end
                    if (all_done) state <= ST_DISPATCH;
                end
                ST_DISPATCH: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                        for (int unsigned i = 0; i < 3; i++) slot_st[i] <= SL_EMPTY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
